// File: rtl/jtag_tap_multi_if.sv
// Signal bundle of jtag_tap_multi: pad-side and DR-side JTAG signals.
// slave is the TAP itself, master is the pad/transport environment.
interface jtag_tap_multi_if #(
  parameter int unsigned IrLength = 5,
  parameter int unsigned NumDr    = 2
);
  logic                tms_i;
  logic                td_i;
  logic                testmode_i;
  logic [IrLength-3:0] ir_status_i;
  logic [NumDr-1:0]    dr_tdo_i;
  logic                td_o;
  logic                tdo_oe_o;
  logic                tck_o;
  logic                trst_no;
  logic                tdi_o;
  logic                capture_o;
  logic                shift_o;
  logic                update_o;
  logic                ir_update_o;
  logic [NumDr-1:0]    dr_select_o;
  logic [3:0]          tap_state_o;

  modport slave (
    input  tms_i,
    input  td_i,
    input  testmode_i,
    input  ir_status_i,
    input  dr_tdo_i,
    output td_o,
    output tdo_oe_o,
    output tck_o,
    output trst_no,
    output tdi_o,
    output capture_o,
    output shift_o,
    output update_o,
    output ir_update_o,
    output dr_select_o,
    output tap_state_o
  );

  modport master (
    output tms_i,
    output td_i,
    output testmode_i,
    output ir_status_i,
    output dr_tdo_i,
    input  td_o,
    input  tdo_oe_o,
    input  tck_o,
    input  trst_no,
    input  tdi_o,
    input  capture_o,
    input  shift_o,
    input  update_o,
    input  ir_update_o,
    input  dr_select_o,
    input  tap_state_o
  );
endinterface

// File: rtl/jtag_tap_multi.sv
// JTAG TAP with NumDr opcode-selected user DR channels,
// BYPASS/IDCODE and a status-reporting IR capture value.
module prim_clock_inv #(
  parameter bit HasScanMode = 1'b1,
  parameter bit NoFpgaBufG  = 1'b0
) (
  input  logic clk_i,
  input  logic scanmode_i,
  output logic clk_no
);
  logic w_inv;

  // no global-buffer model here: both flavours are a plain inverter
  if (NoFpgaBufG) begin : g_nobufg
    assign w_inv = ~clk_i;
  end else begin : g_bufg
    assign w_inv = ~clk_i;
  end

  // scan mode keeps the whole TAP on one clock polarity
  assign clk_no = (HasScanMode && scanmode_i) ? clk_i : w_inv;
endmodule

module jtag_tap_multi #(
  parameter int unsigned               IrLength    = 5,
  parameter int unsigned               NumDr       = 2,
  parameter logic [NumDr*IrLength-1:0] DrOpcodes   = {5'h11, 5'h10},
  parameter logic [31:0]               IdcodeValue = 32'h00000001
) (
  input logic             tck_i,
  input logic             trst_ni,
  jtag_tap_multi_if.slave bus
);
  typedef enum logic [3:0] {
    TestLogicReset = 4'd0,
    RunTestIdle    = 4'd1,
    SelectDrScan   = 4'd2,
    CaptureDr      = 4'd3,
    ShiftDr        = 4'd4,
    Exit1Dr        = 4'd5,
    PauseDr        = 4'd6,
    Exit2Dr        = 4'd7,
    UpdateDr       = 4'd8,
    SelectIrScan   = 4'd9,
    CaptureIr      = 4'd10,
    ShiftIr        = 4'd11,
    Exit1Ir        = 4'd12,
    PauseIr        = 4'd13,
    Exit2Ir        = 4'd14,
    UpdateIr       = 4'd15
  } tap_state_e;

  localparam logic [IrLength-1:0] IrIdcode = IrLength'(1);

  if (IrLength < 3) begin : g_chk_irlen
    $error("jtag_tap_multi: IrLength must be at least 3");
  end
  if (NumDr < 1) begin : g_chk_numdr
    $error("jtag_tap_multi: NumDr must be at least 1");
  end
  if (IdcodeValue[0] != 1'b1) begin : g_chk_idcode
    $error("jtag_tap_multi: IdcodeValue bit 0 must be 1");
  end

  for (genvar k = 0; k < NumDr; k++) begin : g_chk_op
    localparam logic [IrLength-1:0] OpK =
      DrOpcodes[k*IrLength +: IrLength];
    if (OpK == '0 || OpK == IrIdcode || OpK == '1) begin : g_rsvd
      $error("jtag_tap_multi: DR opcode uses a reserved value");
    end
    for (genvar j = k + 1; j < NumDr; j++) begin : g_dup
      if (OpK == DrOpcodes[j*IrLength +: IrLength]) begin : g_eq
        $error("jtag_tap_multi: DR opcodes are not distinct");
      end
    end
  end

  tap_state_e          r_state;
  logic [IrLength-1:0] r_ir_shift;
  logic [IrLength-1:0] r_ir;
  logic [31:0]         r_idcode;
  logic                r_bypass;
  logic                r_td_o;
  logic                r_tdo_oe;

  logic             w_tck_n;
  logic             w_tlr;
  logic             w_cap_dr;
  logic             w_shift_dr;
  logic             w_upd_dr;
  logic             w_cap_ir;
  logic             w_shift_ir;
  logic             w_upd_ir;
  logic             w_sel_idcode;
  logic             w_sel_user;
  logic             w_sel_bypass;
  logic             w_dr_path;
  logic             w_dr_tdo;
  logic             w_tdo_mux;
  logic [NumDr-1:0] w_dr_select;

  assign w_tlr      = (r_state == TestLogicReset);
  assign w_cap_dr   = (r_state == CaptureDr);
  assign w_shift_dr = (r_state == ShiftDr);
  assign w_upd_dr   = (r_state == UpdateDr);
  assign w_cap_ir   = (r_state == CaptureIr);
  assign w_shift_ir = (r_state == ShiftIr);
  assign w_upd_ir   = (r_state == UpdateIr);

  for (genvar k = 0; k < NumDr; k++) begin : g_sel
    assign w_dr_select[k] =
      (r_ir == DrOpcodes[k*IrLength +: IrLength]);
  end

  assign w_sel_idcode = (r_ir == IrIdcode);
  assign w_sel_user   = |w_dr_select;
  assign w_sel_bypass = ~w_sel_idcode & ~w_sel_user;
  assign w_dr_tdo     = |(bus.dr_tdo_i & w_dr_select);
  assign w_dr_path    = ~w_shift_ir;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_state <= TestLogicReset;
    end else begin
      unique case (r_state)
        TestLogicReset:
          r_state <= bus.tms_i ? TestLogicReset : RunTestIdle;
        RunTestIdle:
          r_state <= bus.tms_i ? SelectDrScan : RunTestIdle;
        SelectDrScan:
          r_state <= bus.tms_i ? SelectIrScan : CaptureDr;
        CaptureDr:
          r_state <= bus.tms_i ? Exit1Dr : ShiftDr;
        ShiftDr:
          r_state <= bus.tms_i ? Exit1Dr : ShiftDr;
        Exit1Dr:
          r_state <= bus.tms_i ? UpdateDr : PauseDr;
        PauseDr:
          r_state <= bus.tms_i ? Exit2Dr : PauseDr;
        Exit2Dr:
          r_state <= bus.tms_i ? UpdateDr : ShiftDr;
        UpdateDr:
          r_state <= bus.tms_i ? SelectDrScan : RunTestIdle;
        SelectIrScan:
          r_state <= bus.tms_i ? TestLogicReset : CaptureIr;
        CaptureIr:
          r_state <= bus.tms_i ? Exit1Ir : ShiftIr;
        ShiftIr:
          r_state <= bus.tms_i ? Exit1Ir : ShiftIr;
        Exit1Ir:
          r_state <= bus.tms_i ? UpdateIr : PauseIr;
        PauseIr:
          r_state <= bus.tms_i ? Exit2Ir : PauseIr;
        Exit2Ir:
          r_state <= bus.tms_i ? UpdateIr : ShiftIr;
        UpdateIr:
          r_state <= bus.tms_i ? SelectDrScan : RunTestIdle;
        default:
          r_state <= TestLogicReset;
      endcase
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_ir_shift <= '0;
      r_ir       <= IrIdcode;
    end else if (w_tlr) begin
      r_ir_shift <= '0;
      r_ir       <= IrIdcode;
    end else begin
      if (w_cap_ir) begin
        r_ir_shift <= {bus.ir_status_i, 2'b01};
      end
      if (w_shift_ir) begin
        r_ir_shift <= {bus.td_i, r_ir_shift[IrLength-1:1]};
      end
      if (w_upd_ir) begin
        r_ir <= r_ir_shift;
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_idcode <= IdcodeValue;
      r_bypass <= 1'b0;
    end else if (w_tlr) begin
      r_idcode <= IdcodeValue;
      r_bypass <= 1'b0;
    end else begin
      if (w_sel_idcode && w_cap_dr) begin
        r_idcode <= IdcodeValue;
      end
      if (w_sel_idcode && w_shift_dr) begin
        r_idcode <= {bus.td_i, r_idcode[31:1]};
      end
      if (w_sel_bypass && w_cap_dr) begin
        r_bypass <= 1'b0;
      end
      if (w_sel_bypass && w_shift_dr) begin
        r_bypass <= bus.td_i;
      end
    end
  end

  always_comb begin
    w_tdo_mux = r_bypass;
    unique case (1'b1)
      w_shift_ir:                w_tdo_mux = r_ir_shift[0];
      w_dr_path & w_sel_idcode:  w_tdo_mux = r_idcode[0];
      w_dr_path & w_sel_user:    w_tdo_mux = w_dr_tdo;
      default:                   w_tdo_mux = r_bypass;
    endcase
  end

  prim_clock_inv #(
    .HasScanMode (1'b1),
    .NoFpgaBufG  (1'b1)
  ) u_tck_inv (
    .clk_i      (tck_i),
    .scanmode_i (bus.testmode_i),
    .clk_no     (w_tck_n)
  );

  // TDO launches on the falling edge so the host samples it on the rising one
  always_ff @(posedge w_tck_n or negedge trst_ni) begin
    if (!trst_ni) begin
      r_td_o   <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_td_o   <= w_tdo_mux;
      r_tdo_oe <= w_shift_ir | w_shift_dr;
    end
  end

  assign bus.td_o        = r_td_o;
  assign bus.tdo_oe_o    = r_tdo_oe;
  assign bus.tck_o       = tck_i;
  assign bus.trst_no     = trst_ni & ~w_tlr;
  assign bus.tdi_o       = bus.td_i;
  assign bus.capture_o   = w_cap_dr;
  assign bus.shift_o     = w_shift_dr;
  assign bus.update_o    = w_upd_dr;
  assign bus.ir_update_o = w_upd_ir;
  assign bus.dr_select_o = w_dr_select;
  assign bus.tap_state_o = r_state;
endmodule

// File: doc/jtag_tap_multi.md
# jtag_tap_multi

Parametrised JTAG TAP controller that generalises the single-DMI debug TAP to `NumDr` user data-register channels, each selected by its own configurable IR opcode. It implements the IEEE 1149.1 16-state FSM, built-in BYPASS and IDCODE registers, and an IR capture value that reports live status bits. It sits between the JTAG pads and the debug transport (DTMCS, DMI, and future vendor DRs), which shift their own DRs using the forwarded control strobes.

## Interface
- `IrLength`, default 5: IR width, minimum 3.
- `NumDr`, default 2: number of user DR channels, minimum 1.
- `DrOpcodes`, default `{5'h11, 5'h10}`: packed `NumDr*IrLength` vector; channel k's opcode is slice k (k=0 is the LSB slice).
  - Opcodes must be distinct, must not be 0, 1 or all-ones, and are checked by elaboration assertion.
- `IdcodeValue`, default `32'h00000001`: IDCODE contents; bit 0 must be 1.
- `tck_i`, in, 1: JTAG clock.
- `trst_ni`, in, 1: reset, asynchronous, active-low.
- `tms_i`, in, 1: test mode select.
- `td_i`, in, 1: TDI.
- `testmode_i`, in, 1: scan mode for the TCK inverter.
- `ir_status_i`, in, IrLength-2: status bits loaded into IR[IrLength-1:2] at CaptureIr.
- `td_o`, out, 1: TDO, registered on the falling edge of TCK.
- `tdo_oe_o`, out, 1: TDO enable, registered on the falling edge of TCK.
- `tck_o`, out, 1: forwarded `tck_i`.
- `trst_no`, out, 1: `trst_ni & ~test_logic_reset`.
- `tdi_o`, out, 1: forwarded `td_i`.
- `capture_o`, out, 1: FSM is in CaptureDr.
- `shift_o`, out, 1: FSM is in ShiftDr.
- `update_o`, out, 1: FSM is in UpdateDr.
- `ir_update_o`, out, 1: FSM is in UpdateIr.
- `dr_select_o`, out, NumDr: one-hot channel select decoded from the latched IR.
- `dr_tdo_i`, in, NumDr: serial output of each user DR.
- `tap_state_o`, out, 4: current FSM state, using the encoding listed under Operation.

## Operation
- FSM states and encodings:
  - TestLogicReset=0, RunTestIdle=1, SelectDrScan=2, CaptureDr=3, ShiftDr=4, Exit1Dr=5, PauseDr=6, Exit2Dr=7.
  - UpdateDr=8, SelectIrScan=9, CaptureIr=10, ShiftIr=11, Exit1Ir=12, PauseIr=13, Exit2Ir=14, UpdateIr=15.
- FSM transitions follow IEEE 1149.1 exactly. Five consecutive TCKs with TMS=1 reach TestLogicReset from any state.
- IR shift register:
  - CaptureIr loads `{ir_status_i, 2'b01}`.
  - ShiftIr shifts right: TDI enters the MSB, and the LSB drives TDO.
  - UpdateIr copies the shift register into the latched IR.
- While in TestLogicReset:
  - The IR shift register is cleared to 0 and the latched IR is set to IDCODE.
  - IDCODE is reloaded and BYPASS is cleared.
- DR select from the latched IR:
  - Opcode 1 selects IDCODE.
  - An opcode equal to `DrOpcodes[k]` sets `dr_select_o[k]`.
  - Anything else (0, all-ones, unassigned) selects BYPASS, and `dr_select_o` is 0.
- IDCODE DR: CaptureDr loads `IdcodeValue`; ShiftDr shifts right with TDI entering bit 31.
- BYPASS DR: CaptureDr loads 0; ShiftDr loads TDI.
- TDO mux source:
  - In ShiftIr: IR shift LSB.
  - Otherwise: IDCODE bit 0, `dr_tdo_i[k]` for the selected channel, or the BYPASS bit.
- `tdo_oe_o` is `shift_ir | shift_dr`, sampled on the falling edge.
- The TCK inversion uses `prim_clock_inv` with `HasScanMode=1` and `NoFpgaBufG=1`.

## Timing
- Reset values (while `trst_ni`=0):
  - Internal state: FSM in TestLogicReset, IR=IDCODE, IR shift=0, IDCODE reg=`IdcodeValue`, bypass=0.
  - `td_o`=0, `tdo_oe_o`=0, `trst_no`=0, `dr_select_o`=0.
  - `capture_o`, `shift_o`, `update_o`, `ir_update_o` are all 0; `tap_state_o`=0.
- After reset release, `trst_no` stays 0 while the FSM remains in TestLogicReset.
- All state updates on the rising edge of TCK. `td_o`/`tdo_oe_o` update on the falling edge, a half cycle after the state changes.
- A new IR takes effect (`dr_select_o`, TDO mux) on the rising edge that leaves UpdateIr.
- Strobes are combinational from the current state, so each strobe is high for exactly the one TCK its state is occupied.
- A DR shifted for n TCKs in ShiftDr yields n bits on TDO, first bit = captured bit 0.
- Pausing (PauseDr/PauseIr) holds all shift contents.
- Exit2 back to Shift resumes shifting without a recapture.
- Asserting `trst_ni` mid-shift forces the reset values immediately, with no TCK edge needed.

## Test plan
- Reset, then TMS 0 into RunTestIdle, then DR scan 32 bits -> TDO yields `32'h00000001` LSB first; `tdo_oe_o`=1 only during the 32 shift bits.
- `ir_status_i`=3'b101, IR scan 5 bits -> TDO yields 1,0,1,0,1 (the value 5'b10101, LSB first).
- IR scan 5'h10 and Update, then DR scan with `dr_tdo_i`=2'b01 -> `dr_select_o`=2'b01 and TDO = 1 throughout; `capture_o`/`update_o` each pulse exactly once.
- IR scan 5'h07 (unassigned), then DR scan 4 bits with TDI=1,0,1,1 -> TDO=0,1,0,1 and `dr_select_o`=0.
- In ShiftDr with IR=5'h11, hold TMS=1 for 5 TCKs -> `tap_state_o`=0, IR=IDCODE, `trst_no`=0 while in TestLogicReset.
- Pulse `trst_ni` low mid-ShiftIr with no TCK -> all outputs take their reset values immediately; the next DR scan returns IDCODE.
